pixel_burst_packer: RTL and testbench
=====================================

Name: pixel_burst_packer

Overview:
Inverse of the burst-to-pixel sequentializer in the acquisition path. Accepts a one-pixel-per-beat AXI-Stream of a cropped OUT_ROWS x OUT_COLS image and packs it into PIXELS_PER_BURST-wide bursts with Coaxlink-style frame/line markers on tuser. Sits between the ROI/processing stage and the CustomLogic output DMA port.

Parameters:
PIXEL_BIT_WIDTH, 16, bits per pixel
PIXELS_PER_BURST, 16, pixels per output beat (power of 2, >=2)
USER_WIDTH, 4, output tuser width (fixed map below; >=4)
OUT_ROWS, 48, rows per frame
OUT_COLS, 48, pixels per row (need not be a multiple of PIXELS_PER_BURST)

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  PIXEL_BIT_WIDTH  one pixel
s_axis_sof  in  1  marks first pixel of a frame (resync hint)
m_axis_tvalid  out  1  burst valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  packed burst
m_axis_tuser  out  USER_WIDTH  [0]=SOF [1]=SOL [2]=EOL [3]=EOF, upper bits 0
sync_err  out  1  sticky: frame resync occurred

Behaviour:
- Reset (srst, synchronous, active-high, clock clk): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, sync_err=0; lane, col, row counters=0; accumulator cleared. srst mid-burst discards the partial accumulator and any held output burst without emitting it.
- Lane order: pixel at lane k occupies tdata[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]; lane 0 = lowest column of the burst.
- Accepted pixel (tvalid&&tready) is written into accumulator lane `lane`; col increments; lane increments.
- Burst completes on accepted pixel when lane==PIXELS_PER_BURST-1 OR col==OUT_COLS-1. Lanes not written in a line-final partial burst are 0 (padding).
- On completion: burst plus flags load into output register at the same edge. m_axis_tvalid rises the next cycle (latency 1 cycle from final pixel to m_axis_tvalid). lane resets to 0. The accumulator clears.
- At col==OUT_COLS-1: col->0, row increments. At the last row, row->0 (frame wrap).
- Flags per burst: SOL=burst contains col 0; EOL=burst contains col OUT_COLS-1; SOF=SOL&&row==0; EOF=EOL&&row==OUT_ROWS-1. With a single-burst line, SOL and EOL are both 1.
- Backpressure: s_axis_tready = !completing || !m_axis_tvalid || m_axis_tready.
  - "completing" means the next accepted pixel would complete a burst.
  - Non-final lanes are always accepted.
  - Full throughput: one pixel per cycle, one burst per PIXELS_PER_BURST cycles with m_axis_tready=1.
- Output holds tdata/tuser stable while m_axis_tvalid&&!m_axis_tready (AXIS rule). Simultaneous drain and load in one cycle: the new burst replaces the old one and tvalid stays 1.
- Resync: accepted pixel with s_axis_sof=1 while (row,col)!=(0,0):
  - the partial accumulator is discarded;
  - that pixel is treated as row 0 / col 0 / lane 0;
  - sync_err is set (sticky until srst).
  - s_axis_sof at (0,0) is a no-op. s_axis_sof is ignored when not accepted.
- Bursts already in the output register are never dropped by a resync.

Optional Feature:
PACKER_FRAME_CNT_EN: when defined, adds output port frame_count (16 bits).
- frame_count increments on each output handshake whose tuser[3]=1.
- It wraps at 0xFFFF->0 and resets to 0 on srst.
When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, m_axis_tready=1, frame of 2304 pixels, values = linear index. Required response: 144 bursts.
  - Burst 0: tuser=0011, lane k = k.
  - Burst 2: tuser=0100.
  - Burst 143: tuser=1100, lane 15 = 2303.
  - Zero input stall cycles.
- OUT_COLS=40, one row. Required response: 3 bursts/row. Third burst has lanes 0-7 = cols 32-39, lanes 8-15 = 0, and EOL=1.
- Hold m_axis_tready=0 for 40 cycles mid-frame. Required response: tready drops only when the 16th pixel is pending. tdata/tuser stay stable. No pixel is lost or duplicated after release.
- Assert s_axis_sof on pixel at row 3 col 20. Required response: the partial burst for cols 16-19 is discarded. sync_err=1. Next burst has SOF=SOL=1 and lane 0 = that pixel.
- Assert srst with 7 pixels accumulated and a held output burst. Required response:
  - m_axis_tvalid=0 next cycle.
  - A fresh frame then produces a first burst with SOF=1.
  - sync_err=0.
- PACKER_FRAME_CNT_EN defined, 3 full frames. Required response: frame_count=3. Undefined: build elaborates without the port.

Source files
------------

// File: rtl/pixel_burst_packer.sv
// Packs a one-pixel-per-beat stream into PIXELS_PER_BURST-wide bursts with SOF/SOL/EOL/EOF on tuser.
// Define PACKER_FRAME_CNT_EN to add the 16-bit frame_count output (EOF handshakes since srst).
module pixel_burst_packer #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int PIXELS_PER_BURST = 16,
  parameter int USER_WIDTH       = 4,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48
) (
  input  logic                                         clk,
  input  logic                                         srst,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]                   s_axis_tdata,
  input  logic                                         s_axis_sof,
  output logic                                         m_axis_tvalid,
  input  logic                                         m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0]  m_axis_tdata,
  output logic [USER_WIDTH-1:0]                        m_axis_tuser,
  output logic                                         sync_err
`ifdef PACKER_FRAME_CNT_EN
  ,
  output logic [15:0]                                  frame_count
`endif
);
  localparam int DATA_W = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
  localparam int LANE_W = $clog2(PIXELS_PER_BURST);
  localparam int COL_W  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int ROW_W  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIXELS_PER_BURST - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT_ROWS - 1);

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]     m_tdata_q, m_tdata_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic                  sync_err_q, sync_err_d;

  logic                  completing, accept, resync, complete, sol, eol;
  logic [LANE_W-1:0]     eff_lane;
  logic [COL_W-1:0]      eff_col;
  logic [ROW_W-1:0]      eff_row;
  logic [DATA_W-1:0]     acc_wr;
  logic [PIXEL_BIT_WIDTH-1:0] lane_wr [PIXELS_PER_BURST];

  // Ready only depends on state, so a burst-closing pixel waits for output space.
  assign completing    = (lane_q == LANE_LAST) || (col_q == COL_LAST);
  assign s_axis_tready = !completing || !m_tvalid_q || m_axis_tready;

  always_comb begin
    accept   = s_axis_tvalid && s_axis_tready;
    resync   = accept && s_axis_sof && ((row_q != '0) || (col_q != '0));
    eff_lane = resync ? '0 : lane_q;
    eff_col  = resync ? '0 : col_q;
    eff_row  = resync ? '0 : row_q;
    complete = accept && ((eff_lane == LANE_LAST) || (eff_col == COL_LAST));
    sol      = (int'(eff_col) == int'(eff_lane));
    eol      = (eff_col == COL_LAST);
  end

  // A resync drops the partial burst before the resyncing pixel lands in lane 0.
  for (genvar gi = 0; gi < PIXELS_PER_BURST; gi++) begin : g_lane
    assign lane_wr[gi] = (accept && (eff_lane == LANE_W'(gi))) ? s_axis_tdata :
                         (resync ? '0 : acc_q[gi*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]);
  end

  always_comb begin
    acc_wr = '0;
    for (int k = 0; k < PIXELS_PER_BURST; k++) begin
      acc_wr[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = lane_wr[k];
    end
  end

  always_comb begin
    lane_d     = lane_q;
    col_d      = col_q;
    row_d      = row_q;
    acc_d      = acc_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    sync_err_d = sync_err_q || resync;
    if (accept) begin
      acc_d  = complete ? '0 : acc_wr;
      lane_d = complete ? '0 : eff_lane + LANE_W'(1);
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end
    end
    if (complete) begin
      m_tvalid_d   = 1'b1;
      m_tdata_d    = acc_wr;
      m_tuser_d    = '0;
      m_tuser_d[0] = sol && (eff_row == '0);
      m_tuser_d[1] = sol;
      m_tuser_d[2] = eol;
      m_tuser_d[3] = eol && (eff_row == ROW_LAST);
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      lane_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      col_q      <= col_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign sync_err      = sync_err_q;

`ifdef PACKER_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (m_tvalid_q && m_axis_tready && m_tuser_q[3]) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (srst) frame_count_q <= '0;
    else      frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_pixel_burst_packer.sv
// Bench for pixel_burst_packer: a 48x48 instance (defaults) and a 40-column, 2-row instance,
// each checked every cycle against a column-indexed burst model plus literal expectations.
module tb_pixel_burst_packer;
  localparam int PW  = 16;
  localparam int PPB = 16;
  localparam int DW  = PW * PPB;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    u;
  } burst_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid  [2];
  logic          s_ready  [2];
  logic [PW-1:0] s_data   [2];
  logic          s_sof    [2];
  logic          m_valid  [2];
  logic          m_ready  [2];
  logic [DW-1:0] m_data   [2];
  logic [3:0]    m_user   [2];
  logic          sync_err [2];
`ifdef PACKER_FRAME_CNT_EN
  logic [15:0]   frame_count [2];
`endif

  pixel_burst_packer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(PPB), .USER_WIDTH(4),
                       .OUT_ROWS(48), .OUT_COLS(48)) u_a (
    .clk(clk), .srst(srst),
    .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
    .s_axis_sof(s_sof[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tuser(m_user[0]), .sync_err(sync_err[0])
`ifdef PACKER_FRAME_CNT_EN
    , .frame_count(frame_count[0])
`endif
  );

  pixel_burst_packer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(PPB), .USER_WIDTH(4),
                       .OUT_ROWS(2), .OUT_COLS(40)) u_b (
    .clk(clk), .srst(srst),
    .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
    .s_axis_sof(s_sof[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tuser(m_user[1]), .sync_err(sync_err[1])
`ifdef PACKER_FRAME_CNT_EN
    , .frame_count(frame_count[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pixel position is tracked as (row, col); lane and flags follow from column arithmetic.
  int            m_row [2];
  int            m_col [2];
  logic [PW-1:0] m_acc [2][PPB];
  logic          m_serr[2];
  int            m_fc  [2];
  burst_t        q0[$];
  burst_t        q1[$];

  logic [DW-1:0] cap_d [2][256];
  logic [3:0]    cap_u [2][256];
  int            cap_n [2];
  int            stall_n [2];
  logic          hold  [2];
  logic [DW-1:0] hold_d[2];
  logic [3:0]    hold_u[2];

  function automatic int cols(int i);
    return (i == 0) ? 48 : 40;
  endfunction

  function automatic int rows(int i);
    return (i == 0) ? 48 : 2;
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset(int i);
    m_row[i] = 0; m_col[i] = 0; m_serr[i] = 1'b0; m_fc[i] = 0; hold[i] = 1'b0;
    for (int k = 0; k < PPB; k++) m_acc[i][k] = '0;
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  task automatic model_push(int i, logic [PW-1:0] v, logic sof);
    burst_t b;
    int lane;
    if (sof && (m_row[i] != 0 || m_col[i] != 0)) begin
      for (int k = 0; k < PPB; k++) m_acc[i][k] = '0;
      m_row[i] = 0; m_col[i] = 0; m_serr[i] = 1'b1;
    end
    lane = m_col[i] % PPB;
    m_acc[i][lane] = v;
    if (lane == PPB - 1 || m_col[i] == cols(i) - 1) begin
      for (int k = 0; k < PPB; k++) b.d[k*PW +: PW] = m_acc[i][k];
      b.u[1] = (m_col[i] < PPB);
      b.u[2] = (m_col[i] == cols(i) - 1);
      b.u[0] = b.u[1] && (m_row[i] == 0);
      b.u[3] = b.u[2] && (m_row[i] == rows(i) - 1);
      if (i == 0) q0.push_back(b); else q1.push_back(b);
      for (int k = 0; k < PPB; k++) m_acc[i][k] = '0;
    end
    m_col[i]++;
    if (m_col[i] == cols(i)) begin
      m_col[i] = 0;
      m_row[i]++;
      if (m_row[i] == rows(i)) m_row[i] = 0;
    end
  endtask

  burst_t e;
  logic   compl;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (srst) begin
        model_reset(i);
      end else begin
        chk($sformatf("sync_err[%0d]", i), sync_err[i], m_serr[i]);
        compl = ((m_col[i] % PPB) == PPB - 1) || (m_col[i] == cols(i) - 1);
        chk($sformatf("s_tready[%0d]", i), s_ready[i], !compl || !m_valid[i] || m_ready[i]);
        if (hold[i]) begin
          chk($sformatf("hold_data[%0d]", i), m_data[i], hold_d[i]);
          chk($sformatf("hold_user[%0d]", i), m_user[i], hold_u[i]);
        end
`ifdef PACKER_FRAME_CNT_EN
        chk($sformatf("frame_count[%0d]", i), frame_count[i], 16'(m_fc[i]));
`endif
        if (m_valid[i] && m_ready[i]) begin
          if (qsize(i) == 0) begin
            chk($sformatf("unexpected_burst[%0d]", i), m_user[i], 4'bxxxx);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("burst_data[%0d]", i), m_data[i], e.d);
            chk($sformatf("burst_user[%0d]", i), m_user[i], e.u);
            if (e.u[3]) m_fc[i]++;
          end
          if (cap_n[i] < 256) begin
            cap_d[i][cap_n[i]] = m_data[i];
            cap_u[i][cap_n[i]] = m_user[i];
          end
          cap_n[i]++;
        end
        hold[i]   = m_valid[i] && !m_ready[i];
        hold_d[i] = m_data[i];
        hold_u[i] = m_user[i];
        if (s_valid[i] && s_ready[i]) model_push(i, s_data[i], s_sof[i]);
        if (s_valid[i] && !s_ready[i]) stall_n[i]++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel was taken.
  task automatic send(int i, logic [PW-1:0] v, logic sof);
    int t = 0;
    s_valid[i] = 1'b1; s_data[i] = v; s_sof[i] = sof;
    @(negedge clk);
    while (!s_ready[i]) begin
      t++;
      if (t > 500) begin
        $display("FAIL send_timeout[%0d]: got no tready expected tready within 500 cycles", i);
        $fatal(1, "input stalled");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_sof[i] = 1'b0;
  endtask

  task automatic drain(int i);
    int t = 0;
    s_valid[i] = 1'b0;
    while ((qsize(i) != 0 || m_valid[i]) && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    chk($sformatf("drain_done[%0d]", i), qsize(i) == 0 && !m_valid[i], 1'b1);
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] ev;

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_sof[i] = 1'b0; m_ready[i] = 1'b1;
      cap_n[i] = 0; stall_n[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_tvalid[%0d]", i), m_valid[i], 1'b0);
      chk($sformatf("rst_tdata[%0d]", i), m_data[i], '0);
      chk($sformatf("rst_tuser[%0d]", i), m_user[i], 4'b0000);
      chk($sformatf("rst_sync_err[%0d]", i), sync_err[i], 1'b0);
      chk($sformatf("rst_tready[%0d]", i), s_ready[i], 1'b1);
    end
    @(posedge clk); #1;

    // Full frame, linear data, no backpressure
    cap_n[0] = 0; stall_n[0] = 0;
    for (int n = 0; n < 2304; n++) send(0, 16'(n), n == 0);
    drain(0);
    chk("f1_bursts", 32'(cap_n[0]), 32'd144);
    chk("f1_stalls", 32'(stall_n[0]), 32'd0);
    ev = '0;
    for (int k = 0; k < PPB; k++) ev[k*PW +: PW] = 16'(k);
    chk("f1_b0_data", cap_d[0][0], ev);
    chk("f1_b0_user", cap_u[0][0], 4'b0011);
    chk("f1_b2_user", cap_u[0][2], 4'b0100);
    chk("f1_b143_user", cap_u[0][143], 4'b1100);
    chk("f1_b143_lane15", cap_d[0][143][DW-1 -: PW], 16'd2303);

    // Output held off for 40 cycles mid-frame
    cap_n[0] = 0; stall_n[0] = 0;
    fork
      begin
        for (int n = 0; n < 2304; n++) send(0, 16'(n + 5000), n == 0);
      end
      begin
        repeat (100) @(posedge clk);
        #1 m_ready[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1 m_ready[0] = 1'b1;
      end
    join
    drain(0);
    chk("bp_bursts", 32'(cap_n[0]), 32'd144);
    chk("bp_stalled", stall_n[0] > 0, 1'b1);

    // Resync at row 3 col 20
    cap_n[0] = 0;
    for (int n = 0; n < 164; n++) send(0, 16'(n + 16'h1000), 1'b0);
    send(0, 16'hABCD, 1'b1);
    for (int n = 1; n < 2304; n++) send(0, 16'(n + 16'h2000), 1'b0);
    drain(0);
    chk("rs_sync_err", sync_err[0], 1'b1);
    chk("rs_bursts", 32'(cap_n[0]), 32'd154);
    chk("rs_b9_user", cap_u[0][9], 4'b0010);
    chk("rs_b10_user", cap_u[0][10], 4'b0011);
    chk("rs_b10_lane0", cap_d[0][10][PW-1:0], 16'hABCD);
    chk("rs_b10_lane1", cap_d[0][10][2*PW-1 -: PW], 16'h2001);
`ifdef PACKER_FRAME_CNT_EN
    chk("fc_three_frames", frame_count[0], 16'd3);
`endif

    // srst with a held burst and 7 accumulated pixels
    m_ready[0] = 1'b0;
    for (int n = 0; n < 23; n++) send(0, 16'(n + 16'h3000), 1'b0);
    s_valid[0] = 1'b0;
    chk("pre_rst_tvalid", m_valid[0], 1'b1);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    chk("post_rst_tvalid", m_valid[0], 1'b0);
    chk("post_rst_sync_err", sync_err[0], 1'b0);
    @(posedge clk); #1;
    m_ready[0] = 1'b1;
    cap_n[0] = 0;
    for (int n = 0; n < 2304; n++) send(0, 16'(n + 100), n == 0);
    drain(0);
    chk("post_rst_bursts", 32'(cap_n[0]), 32'd144);
    chk("post_rst_b0_user", cap_u[0][0], 4'b0011);
    chk("post_rst_b0_lane0", cap_d[0][0][PW-1:0], 16'd100);

    // 40-column instance: line-final partial burst is zero-padded
    cap_n[1] = 0;
    for (int n = 0; n < 80; n++) send(1, 16'(n), n == 0);
    drain(1);
    chk("c40_bursts", 32'(cap_n[1]), 32'd6);
    ev = '0;
    for (int k = 0; k < 8; k++) ev[k*PW +: PW] = 16'(32 + k);
    chk("c40_b2_data", cap_d[1][2], ev);
    chk("c40_b2_user", cap_u[1][2], 4'b0100);
    chk("c40_b3_user", cap_u[1][3], 4'b0010);
    chk("c40_b5_user", cap_u[1][5], 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
